// File: rtl/mux_pkg.sv
// Shared constants, select-mode enum and width helper
// for the N:1 pipelined channel mux.
package mux_pkg;

  localparam int N_CH_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 1;

  typedef enum logic {
    SEL_FIXED,
    SEL_RR
  } sel_mode_t;

  function automatic int sw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search over REQ starting at PTR.
// PTR moves past the winner only when ADV is asserted.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT,
  parameter int SW   = sw_of(N_CH)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] REQ,
  input  logic            ADV,
  output logic [SW-1:0]   GNT_IDX,
  output logic            GNT_VLD
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  // Scan farthest-first so the nearest request wins.
  always_comb begin
    GNT_IDX = '0;
    GNT_VLD = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= N_CH) j = j - N_CH;
      if (REQ[j]) begin
        GNT_IDX = SW'(j);
        GNT_VLD = 1'b1;
      end
    end
  end

  // Pointer lands just past the granted channel.
  always_comb begin
    ptr_d = ptr_q;
    if (ADV) begin
      if (GNT_IDX == SW'(N_CH - 1)) ptr_d = '0;
      else ptr_d = GNT_IDX + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_n1_pipe.sv
// N:1 channel mux with one output register, fixed or
// round-robin select. MUX_N1_PIPE_PARITY_EN adds Y_PAR.
module mux_n1_pipe
  import mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SW    = sw_of(N_CH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_CH*WIDTH-1:0] D,
  input  logic [N_CH-1:0]       D_VALID,
  output logic [N_CH-1:0]       D_READY,
  input  logic [SW-1:0]         S,
  input  logic                  S_AUTO,
  output logic [WIDTH-1:0]      Y,
  output logic [SW-1:0]         Y_CH,
  output logic                  Y_VALID,
`ifdef MUX_N1_PIPE_PARITY_EN
  output logic                  Y_PAR,
`endif
  input  logic                  Y_READY
);

  sel_mode_t        mode;
  logic             open;
  logic             xfer;
  logic [SW-1:0]    sel_idx;
  logic             sel_hit;
  logic             sel_vld;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    rr_idx;
  logic             rr_vld;

  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    ch_q, ch_d;
  logic             vld_q, vld_d;

  assign mode = S_AUTO ? SEL_RR : SEL_FIXED;
  // Reset term keeps D_READY low while RST_N is held.
  assign open = RST_N & (~vld_q | Y_READY);
  assign xfer = open & sel_vld;

  rr_arbiter #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_arb (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (D_VALID),
    .ADV     (xfer & (mode == SEL_RR)),
    .GNT_IDX (rr_idx),
    .GNT_VLD (rr_vld)
  );

  // Pick the addressed channel; out-of-range S hits nothing.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    sel_vld = 1'b0;
    unique case (mode)
      SEL_RR: begin
        sel_idx = rr_idx;
        sel_hit = rr_vld;
        sel_vld = rr_vld;
      end
      SEL_FIXED: begin
        sel_idx = S;
        for (int k = 0; k < N_CH; k++) begin
          if (S == SW'(k)) begin
            sel_hit = 1'b1;
            sel_vld = D_VALID[k];
          end
        end
      end
      default: ;
    endcase
  end

  // One-hot ready and data steering for the addressed channel.
  always_comb begin
    D_READY  = '0;
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_hit && (sel_idx == SW'(k))) begin
        D_READY[k] = open;
        sel_data   = D[k*WIDTH +: WIDTH];
      end
    end
  end

  // Load on transfer, else retire on handshake, else hold.
  always_comb begin
    y_d   = y_q;
    ch_d  = ch_q;
    vld_d = vld_q;
    if (xfer) begin
      y_d   = sel_data;
      ch_d  = sel_idx;
      vld_d = 1'b1;
    end else if (Y_READY) begin
      vld_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q   <= '0;
      ch_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      ch_q  <= ch_d;
      vld_q <= vld_d;
    end
  end

  assign Y       = y_q;
  assign Y_CH    = ch_q;
  assign Y_VALID = vld_q;

`ifdef MUX_N1_PIPE_PARITY_EN
  logic par_q;

  // Even parity of the word loaded into Y.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) par_q <= 1'b0;
    else if (xfer) par_q <= ^sel_data;
  end

  assign Y_PAR = par_q;
`endif

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Directed bench for mux_n1_pipe (4x8 main, 3x4 for
// out-of-range select).
module tb_mux_n1_pipe;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N*W-1:0] D;
  logic [N-1:0]   D_VALID, D_READY;
  logic [SW-1:0]  S;
  logic           S_AUTO;
  logic [W-1:0]   Y;
  logic [SW-1:0]  Y_CH;
  logic           Y_VALID, Y_READY;

  logic [11:0] d3;
  logic [2:0]  dv3, dr3;
  logic [1:0]  s3, ych3;
  logic [3:0]  y3;
  logic        yv3;

`ifdef MUX_N1_PIPE_PARITY_EN
  logic Y_PAR, y3_par;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] dat [4];

  always #5 CLK = ~CLK;

  mux_n1_pipe #(.N_CH(N), .WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .D_VALID(D_VALID),
    .D_READY(D_READY), .S(S), .S_AUTO(S_AUTO), .Y(Y),
    .Y_CH(Y_CH), .Y_VALID(Y_VALID),
`ifdef MUX_N1_PIPE_PARITY_EN
    .Y_PAR(Y_PAR),
`endif
    .Y_READY(Y_READY)
  );

  mux_n1_pipe #(.N_CH(3), .WIDTH(4)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .D(d3), .D_VALID(dv3),
    .D_READY(dr3), .S(s3), .S_AUTO(1'b0), .Y(y3),
    .Y_CH(ych3), .Y_VALID(yv3),
`ifdef MUX_N1_PIPE_PARITY_EN
    .Y_PAR(y3_par),
`endif
    .Y_READY(1'b1)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; D = '1; D_VALID = '1; S = '0;
    S_AUTO = 1'b0; Y_READY = 1'b1;
    d3 = '1; dv3 = '1; s3 = '0;
    #2;
    checks++;
    if (Y !== 8'h00 || Y_CH !== 2'd0 || Y_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got y=%h ch=%0d v=%b exp 00 0 0",
               Y, Y_CH, Y_VALID);
    end
    checks++;
    if (D_READY !== 4'b0000 || dr3 !== 3'b000) begin
      errors++;
      $display("FAIL rst_ready got %b/%b exp 0000/000",
               D_READY, dr3);
    end
    tick; tick;
    checks++;
    if (Y_VALID !== 1'b0 || yv3 !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold got v=%b/%b exp 0/0", Y_VALID, yv3);
    end
    RST_N = 1'b1; D_VALID = '0; dv3 = '0;
  endtask

  task automatic test_fixed;
    D = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    D_VALID = '1; S_AUTO = 1'b0; Y_READY = 1'b1;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1;
      checks++;
      if (D_READY !== (4'b0001 << s)) begin
        errors++;
        $display("FAIL fix_ready s=%0d got %b exp %b",
                 s, D_READY, 4'b0001 << s);
      end
      tick;
      checks++;
      if (Y !== dat[s] || Y_CH !== 2'(s) || Y_VALID !== 1'b1) begin
        errors++;
        $display("FAIL fix_out s=%0d got %h ch%0d v%b exp %h ch%0d v1",
                 s, Y, Y_CH, Y_VALID, dat[s], s);
      end
    end
  endtask

  task automatic test_backpressure;
    Y_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S = 2'(i);
      D = {4{8'(8'h50 + i)}};
      #1;
      checks++;
      if (D_READY !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready i=%0d got %b exp 0000", i, D_READY);
      end
      tick;
      checks++;
      if (Y !== 8'hDD || Y_CH !== 2'd3 || Y_VALID !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold i=%0d got %h ch%0d v%b exp dd ch3 v1",
                 i, Y, Y_CH, Y_VALID);
      end
    end
    D = {8'h44, 8'h33, 8'h22, 8'h11};
    S = 2'd1; Y_READY = 1'b1;
    #1;
    checks++;
    if (D_READY !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_ready got %b exp 0010", D_READY);
    end
    tick;
    checks++;
    if (Y !== 8'h22 || Y_CH !== 2'd1 || Y_VALID !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %h ch%0d v%b exp 22 ch1 v1",
               Y, Y_CH, Y_VALID);
    end
    D_VALID = '0;
    tick;
    checks++;
    if (Y !== 8'h22 || Y_CH !== 2'd1 || Y_VALID !== 1'b0) begin
      errors++;
      $display("FAIL drain got %h ch%0d v%b exp 22 ch1 v0",
               Y, Y_CH, Y_VALID);
    end
  endtask

  task automatic test_rr;
    int seq [6];
    seq = '{0, 1, 3, 0, 1, 3};
    D = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    S_AUTO = 1'b1; D_VALID = 4'b1011; Y_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (D_READY !== (4'b0001 << seq[i])) begin
        errors++;
        $display("FAIL rr_ready i=%0d got %b exp %b",
                 i, D_READY, 4'b0001 << seq[i]);
      end
      tick;
      checks++;
      if (Y_CH !== 2'(seq[i]) || Y !== dat[seq[i]] || Y_VALID !== 1'b1) begin
        errors++;
        $display("FAIL rr_out i=%0d got ch%0d %h exp ch%0d %h",
                 i, Y_CH, Y, seq[i], dat[seq[i]]);
      end
    end
  endtask

  task automatic test_rr_wrap;
    D_VALID = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (D_READY !== 4'b0100) begin
        errors++;
        $display("FAIL wrap_ready i=%0d got %b exp 0100", i, D_READY);
      end
      tick;
      checks++;
      if (Y_CH !== 2'd2 || Y !== 8'hCC) begin
        errors++;
        $display("FAIL wrap_out i=%0d got ch%0d %h exp ch2 cc",
                 i, Y_CH, Y);
      end
    end
    S_AUTO = 1'b0; S = 2'd1; D_VALID = 4'b1111;
    #1;
    tick;
    checks++;
    if (Y_CH !== 2'd1 || Y !== 8'hBB) begin
      errors++;
      $display("FAIL fix_in_rr got ch%0d %h exp ch1 bb", Y_CH, Y);
    end
    S_AUTO = 1'b1;
    #1;
    checks++;
    if (D_READY !== 4'b1000) begin
      errors++;
      $display("FAIL ptr_kept got %b exp 1000", D_READY);
    end
    tick;
    checks++;
    if (Y_CH !== 2'd3 || Y !== 8'hDD) begin
      errors++;
      $display("FAIL ptr_kept_out got ch%0d %h exp ch3 dd", Y_CH, Y);
    end
    D_VALID = '0;
    tick;
    checks++;
    if (Y_VALID !== 1'b0) begin
      errors++;
      $display("FAIL idle got v=%b exp 0", Y_VALID);
    end
  endtask

  task automatic test_out_of_range;
    d3 = {4'hC, 4'hB, 4'hA}; dv3 = 3'b111; s3 = 2'd3;
    #1;
    checks++;
    if (dr3 !== 3'b000) begin
      errors++;
      $display("FAIL oor_ready got %b exp 000", dr3);
    end
    tick;
    checks++;
    if (yv3 !== 1'b0) begin
      errors++;
      $display("FAIL oor_valid got %b exp 0", yv3);
    end
    s3 = 2'd2;
    #1;
    checks++;
    if (dr3 !== 3'b100) begin
      errors++;
      $display("FAIL oor_edge_ready got %b exp 100", dr3);
    end
    tick;
    checks++;
    if (y3 !== 4'hC || ych3 !== 2'd2 || yv3 !== 1'b1) begin
      errors++;
      $display("FAIL oor_edge_out got %h ch%0d v%b exp c ch2 v1",
               y3, ych3, yv3);
    end
    dv3 = '0;
  endtask

  task automatic test_reset_mid_hold;
    D = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    S_AUTO = 1'b0; S = 2'd2; D_VALID = '1; Y_READY = 1'b1;
    tick;
    checks++;
    if (Y !== 8'hCC || Y_CH !== 2'd2 || Y_VALID !== 1'b1) begin
      errors++;
      $display("FAIL hold_load got %h ch%0d v%b exp cc ch2 v1",
               Y, Y_CH, Y_VALID);
    end
    Y_READY = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (Y !== 8'h00 || Y_CH !== 2'd0 || Y_VALID !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got %h ch%0d v%b exp 00 ch0 v0",
               Y, Y_CH, Y_VALID);
    end
    checks++;
    if (D_READY !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst_ready got %b exp 0000", D_READY);
    end
    #1;
    RST_N = 1'b1; D_VALID = '0; Y_READY = 1'b1;
    tick;
    checks++;
    if (Y_VALID !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got v=%b exp 0", Y_VALID);
    end
  endtask

`ifdef MUX_N1_PIPE_PARITY_EN
  task automatic test_parity;
    S_AUTO = 1'b0; S = 2'd0; D_VALID = '1; Y_READY = 1'b1;
    D = {8'hDD, 8'hCC, 8'hBB, 8'h07};
    tick;
    checks++;
    if (Y !== 8'h07 || Y_PAR !== 1'b1) begin
      errors++;
      $display("FAIL par_07 got %h p%b exp 07 p1", Y, Y_PAR);
    end
    D = {8'hDD, 8'hCC, 8'hBB, 8'h03};
    tick;
    checks++;
    if (Y !== 8'h03 || Y_PAR !== 1'b0) begin
      errors++;
      $display("FAIL par_03 got %h p%b exp 03 p0", Y, Y_PAR);
    end
    D_VALID = '0;
  endtask
`endif

  initial begin
    dat[0] = 8'hAA; dat[1] = 8'hBB;
    dat[2] = 8'hCC; dat[3] = 8'hDD;
    test_reset;
    test_fixed;
    test_backpressure;
    test_rr;
    test_rr_wrap;
    test_out_of_range;
    test_reset_mid_hold;
`ifdef MUX_N1_PIPE_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
